// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency: DATA_WIDTH cycles from accept to DONE; divide-by-zero and signed overflow finish on the accept edge.
// Backpressure: start_i is taken only in IDLE or DONE; busy_o holds off the issuer while in CALC.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DW-1:0]         a_q, a_d;
    logic [DW-1:0]         acc_q, acc_d;
    logic [DW-1:0]         lo_q, lo_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  rneg_q, rneg_d;
    logic [DW-1:0]         result_q, result_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    // Operand decode for the request currently on the inputs
    logic          in_div, a_sgn, b_sgn, sa, sb, div_zero, div_ovf, fast, accept;
    logic [DW-1:0] mag_a, mag_b, fast_res;

    assign in_div   = op_i[2];
    assign a_sgn    = in_div ? !op_i[0] : (op_i == 3'd1 || op_i == 3'd2);
    assign b_sgn    = in_div ? !op_i[0] : (op_i == 3'd1);
    assign sa       = a_sgn & rs1_i[DW-1];
    assign sb       = b_sgn & rs2_i[DW-1];
    assign mag_a    = sa ? -rs1_i : rs1_i;
    assign mag_b    = sb ? -rs2_i : rs2_i;
    assign div_zero = (rs2_i == '0);
    assign div_ovf  = !op_i[0] && (rs1_i == {1'b1, {(DW-1){1'b0}}}) && (rs2_i == '1);
    assign fast     = in_div && (div_zero || div_ovf);
    assign fast_res = div_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
    assign accept   = start_i && !flush_i && (state_q != CALC);

    // One iteration: acc/lo hold {product hi, multiplier} or {remainder, dividend->quotient}
    logic [DW:0]     mul_sum, div_shift, div_diff;
    logic            div_ge;
    logic [DW-1:0]   step_hi, step_lo;
    logic [2*DW-1:0] prod, prod_s;
    logic [DW-1:0]   final_res;

    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign div_shift = {acc_q, lo_q[DW-1]};
    assign div_diff  = div_shift - {1'b0, a_q};
    assign div_ge    = !div_diff[DW];
    assign step_hi   = op_q[2] ? (div_ge ? div_diff[DW-1:0] : div_shift[DW-1:0]) : mul_sum[DW:1];
    assign step_lo   = op_q[2] ? {lo_q[DW-2:0], div_ge} : {mul_sum[0], lo_q[DW-1:1]};
    assign prod      = {step_hi, step_lo};
    assign prod_s    = neg_q ? -prod : prod;

    always_comb begin
        final_res = '0;
        case (op_q)
            3'd0:         final_res = prod_s[DW-1:0];
            3'd1, 3'd2,
            3'd3:         final_res = prod_s[2*DW-1:DW];
            3'd4, 3'd5:   final_res = neg_q ? -step_lo : step_lo;
            default:      final_res = rneg_q ? -step_hi : step_hi;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        a_d       = a_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;
        rd_addr_d = rd_addr_q;

        case (state_q)
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d   = DONE;
                        result_d  = final_res;
                        rd_addr_d = rd_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A start in DONE overrides the return to IDLE, so the current pulse still completes
        if (accept) begin
            op_d   = op_i;
            rd_d   = rd_addr_i;
            neg_d  = sa ^ sb;
            rneg_d = sa;
            cnt_d  = '0;
            acc_d  = '0;
            a_d    = in_div ? mag_b : mag_a;
            lo_d   = in_div ? mag_a : mag_b;
            if (fast) begin
                state_d   = DONE;
                result_d  = fast_res;
                rd_addr_d = rd_addr_i;
            end else begin
                state_d = CALC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign busy_o    = (state_q == CALC);
    assign valid_o   = (state_q == DONE);
    assign result_o  = result_q;
    assign rd_addr_o = rd_addr_q;
endmodule
